// File: rtl/dmem_io_bridge.sv
// rtl/dmem_io_bridge.sv - data RAM plus posted-write FIFO to a peripheral bus; optional sticky overflow via DMEM_IO_OVF_EN
module dmem_io_bridge #(
   parameter int DMEM_AW    = 10,
   parameter int WBUF_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] me_ExtMemAddr,
   input  logic [31:0] me_ExtMemWrData,
   input  logic        me_ExtMemWrEn,
   input  logic        me_ExtMemRdEn,
   output logic [31:0] me_ExtMemRdData,
   output logic        io_Req,
   output logic [31:0] io_Addr,
   output logic [31:0] io_WrData,
   input  logic        io_Ack
);

   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int RAM_WORDS = 1 << DMEM_AW;

   // Region decode and RAM word index; upper address bits alias, byte offset is ignored.
   logic               ioSel;
   logic [DMEM_AW-1:0] ramIdx;
   logic               unusedAddrBits;

   assign ioSel          = me_ExtMemAddr[31];
   assign ramIdx         = me_ExtMemAddr[DMEM_AW+1:2];
   assign unusedAddrBits = ^{me_ExtMemAddr[30:DMEM_AW+2], me_ExtMemAddr[1:0]};

   // Data RAM; contents survive reset.
   logic [31:0] ram [RAM_WORDS];
   logic [31:0] ramRdData;

   assign ramRdData = ram[ramIdx];

   // RAM store at the clock edge; a same-cycle load sees the old word.
   always_ff @(posedge clock) begin
      if (me_ExtMemWrEn && !ioSel) begin
         ram[ramIdx] <= me_ExtMemWrData;
      end
   end

   // Posted-write FIFO state.
   logic [31:0]   addrMem [WBUF_DEPTH];
   logic [31:0]   dataMem [WBUF_DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [CW-1:0] count;
   logic          fifoEmpty;
   logic          fifoFull;
   logic          ioStore;
   logic          pop;
   logic          push;
   logic          drop;
   logic          statusRead;
   logic          overflow;

   assign fifoEmpty  = (count == '0);
   assign fifoFull   = (count == CW'(WBUF_DEPTH));
   assign ioStore    = me_ExtMemWrEn && ioSel;
   assign pop        = io_Req && io_Ack;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the store.
   assign push       = ioStore && (!fifoFull || pop);
   assign drop       = ioStore && fifoFull && !pop;
   assign statusRead = me_ExtMemRdEn && ioSel;

   // Request follows the registered count; head fields read as zero while idle.
   assign io_Req    = !fifoEmpty;
   assign io_Addr   = io_Req ? addrMem[rdPtr] : '0;
   assign io_WrData = io_Req ? dataMem[rdPtr] : '0;

   // FIFO entry storage; pending entries are discarded by clearing the count, not the storage.
   always_ff @(posedge clock) begin
      if (push) begin
         addrMem[wrPtr] <= me_ExtMemAddr;
         dataMem[wrPtr] <= me_ExtMemWrData;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef DMEM_IO_OVF_EN
   // Sticky overflow: a drop sets it, a status read clears it, and a drop wins a tie.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (statusRead) begin
         overflow <= 1'b0;
      end
   end
`else
   logic unusedDrop;

   assign overflow   = 1'b0;
   assign unusedDrop = drop;
`endif

   // Status word and load-data mux.
   logic [3:0]  countExt;
   logic [31:0] statusWord;

   assign countExt   = 4'(count);
   assign statusWord = {20'b0, countExt, 5'b0, overflow, fifoFull, fifoEmpty};

   // Loads return RAM data or FIFO status; zero when no load is in progress.
   always_comb begin
      me_ExtMemRdData = '0;
      if (me_ExtMemRdEn) begin
         me_ExtMemRdData = ioSel ? statusWord : ramRdData;
      end
   end

endmodule

// File: tb/tb_dmem_io_bridge.sv
// tb/tb_dmem_io_bridge.sv - directed self-checking bench for dmem_io_bridge
module tb_dmem_io_bridge;

   logic        clock;
   logic        reset;
   logic [31:0] me_ExtMemAddr;
   logic [31:0] me_ExtMemWrData;
   logic        me_ExtMemWrEn;
   logic        me_ExtMemRdEn;
   logic [31:0] me_ExtMemRdData;
   logic        io_Req;
   logic [31:0] io_Addr;
   logic [31:0] io_WrData;
   logic        io_Ack;

   int nAsserts = 0;
   int nFails   = 0;

`ifdef DMEM_IO_OVF_EN
   localparam logic [31:0] OVF = 32'h0000_0004;
`else
   localparam logic [31:0] OVF = 32'h0000_0000;
`endif

   dmem_io_bridge #(.DMEM_AW(10), .WBUF_DEPTH(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .me_ExtMemAddr   (me_ExtMemAddr),
      .me_ExtMemWrData (me_ExtMemWrData),
      .me_ExtMemWrEn   (me_ExtMemWrEn),
      .me_ExtMemRdEn   (me_ExtMemRdEn),
      .me_ExtMemRdData (me_ExtMemRdData),
      .io_Req          (io_Req),
      .io_Addr         (io_Addr),
      .io_WrData       (io_WrData),
      .io_Ack          (io_Ack)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nAsserts++;
      assert (obs === expv) else begin
         nFails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic idle();
      me_ExtMemWrEn   = 1'b0;
      me_ExtMemRdEn   = 1'b0;
      me_ExtMemAddr   = 32'h0;
      me_ExtMemWrData = 32'h0;
   endtask

   // Drives a one-cycle store at the current negedge and returns at the next negedge.
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      me_ExtMemAddr   = a;
      me_ExtMemWrData = d;
      me_ExtMemWrEn   = 1'b1;
      me_ExtMemRdEn   = 1'b0;
      @(negedge clock);
      idle();
   endtask

   // Combinational load sampled mid-cycle; the strobe stays up across the next edge.
   task automatic load(input string tag, input logic [31:0] a, input logic [31:0] expv);
      me_ExtMemAddr = a;
      me_ExtMemRdEn = 1'b1;
      me_ExtMemWrEn = 1'b0;
      #1;
      check(tag, me_ExtMemRdData, expv);
      @(negedge clock);
      idle();
   endtask

   initial begin
      reset  = 1'b0;
      io_Ack = 1'b0;
      idle();
      #1;
      check("rst_req", {31'b0, io_Req}, 32'h0);
      check("rst_addr", io_Addr, 32'h0);
      check("rst_wdata", io_WrData, 32'h0);
      check("rst_rdata_idle", me_ExtMemRdData, 32'h0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      load("status_after_reset", 32'h8000_0000, 32'h0000_0001);

      // RAM store/load, aliasing, byte-offset ignore, read-during-write
      store(32'h0000_0010, 32'hDEAD_BEEF);
      load("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
      load("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
      store(32'h0000_0017, 32'h1234_5678);
      load("ram_byteoff", 32'h0000_0014, 32'h1234_5678);
      load("ram_neighbour", 32'h0000_0010, 32'hDEAD_BEEF);
      me_ExtMemAddr   = 32'h0000_0010;
      me_ExtMemWrData = 32'hCAFE_F00D;
      me_ExtMemWrEn   = 1'b1;
      me_ExtMemRdEn   = 1'b1;
      #1;
      check("ram_rdw_old", me_ExtMemRdData, 32'hDEAD_BEEF);
      @(negedge clock);
      idle();
      load("ram_rdw_new", 32'h0000_0010, 32'hCAFE_F00D);

      // Posted write held for three cycles without ack
      me_ExtMemAddr   = 32'h8000_0004;
      me_ExtMemWrData = 32'h0000_0055;
      me_ExtMemWrEn   = 1'b1;
      #1;
      check("post_req_before_edge", {31'b0, io_Req}, 32'h0);
      @(negedge clock);
      idle();
      for (int i = 0; i < 3; i++) begin
         check("post_req_held", {31'b0, io_Req}, 32'h1);
         check("post_addr_held", io_Addr, 32'h8000_0004);
         check("post_data_held", io_WrData, 32'h0000_0055);
         @(negedge clock);
      end
      io_Ack = 1'b1;
      @(negedge clock);
      io_Ack = 1'b0;
      #1;
      check("post_req_after_ack", {31'b0, io_Req}, 32'h0);
      load("post_status_empty", 32'h8000_0000, 32'h0000_0001);

      // Overflow: four queued, fifth dropped
      for (int i = 0; i < 5; i++) begin
         store(32'h8000_0100 + 32'(4 * i), 32'(i + 1));
      end
      load("ovf_status1", 32'h8000_0000, 32'h0000_0402 | OVF);
      load("ovf_status2", 32'h8000_0000, 32'h0000_0402);
      check("ovf_head_addr", io_Addr, 32'h8000_0100);
      check("ovf_head_data", io_WrData, 32'h0000_0001);

      // Drop coinciding with a status read: read shows old state, flag ends up set
      me_ExtMemAddr   = 32'h8000_0200;
      me_ExtMemWrData = 32'h0000_00EE;
      me_ExtMemWrEn   = 1'b1;
      me_ExtMemRdEn   = 1'b1;
      #1;
      check("drop_read_same", me_ExtMemRdData, 32'h0000_0402);
      @(negedge clock);
      idle();
      load("drop_read_setwins", 32'h8000_0000, 32'h0000_0402 | OVF);
      load("drop_read_cleared", 32'h8000_0000, 32'h0000_0402);

      // Full FIFO: push and pop in the same cycle
      io_Ack = 1'b1;
      store(32'h8000_0110, 32'h0000_0005);
      me_ExtMemAddr = 32'h8000_0000;
      me_ExtMemRdEn = 1'b1;
      #1;
      check("fullpp_status", me_ExtMemRdData, 32'h0000_0402);
      for (int i = 2; i <= 5; i++) begin
         check("drain_addr", io_Addr, 32'h8000_0100 + 32'(4 * (i - 1)));
         check("drain_data", io_WrData, 32'(i));
         @(negedge clock);
         idle();
         #1;
      end
      check("drain_req_low", {31'b0, io_Req}, 32'h0);
      load("drain_status", 32'h8000_0000, 32'h0000_0001);

      // Ack while idle is ignored; a store with ack held drains one cycle later
      store(32'h8000_0020, 32'h0000_00AA);
      check("ackidle_req", {31'b0, io_Req}, 32'h1);
      check("ackidle_addr", io_Addr, 32'h8000_0020);
      @(negedge clock);
      check("ackidle_popped", {31'b0, io_Req}, 32'h0);
      io_Ack = 1'b0;

      // Asynchronous reset in the middle of a handshake
      store(32'h8000_0030, 32'h0000_0011);
      store(32'h8000_0034, 32'h0000_0022);
      load("rstmid_status", 32'h8000_0000, 32'h0000_0200);
      check("rstmid_req_before", {31'b0, io_Req}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check("rstmid_req", {31'b0, io_Req}, 32'h0);
      check("rstmid_addr", io_Addr, 32'h0);
      check("rstmid_data", io_WrData, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      load("rstmid_status_after", 32'h8000_0000, 32'h0000_0001);
      load("ram_survives_reset", 32'h0000_0010, 32'hCAFE_F00D);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/dmem_io_bridge.md
# dmem_io_bridge

Data-side memory subsystem that sits directly downstream of the core's memory stage and consumes its external data port (`me_ExtMemAddr`, `me_ExtMemWrData`, `me_ExtMemWrEn`, `me_ExtMemRdEn`). It returns `me_ExtMemRdData` to write-back. Low addresses map to a local word-addressed data RAM. High addresses map to a posted-write FIFO that drains to a slow peripheral bus over a req/ack handshake. Reads in the I/O region return a FIFO status word, so the core never waits on the data side.

## Interface
Parameters:
- `DMEM_AW`, 10: RAM word-address width (2^DMEM_AW words of 32 bits).
- `WBUF_DEPTH`, 4: posted-write FIFO depth; must be a power of 2, range 2..8.

Ports (one clock; reset is asynchronous and active-low):
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `me_ExtMemAddr`, input, 32: byte address from the memory stage.
- `me_ExtMemWrData`, input, 32: store data.
- `me_ExtMemWrEn`, input, 1: store strobe, one cycle per store.
- `me_ExtMemRdEn`, input, 1: load strobe.
- `me_ExtMemRdData`, output, 32: load data, combinational.
- `io_Req`, output, 1: peripheral write request.
- `io_Addr`, output, 32: peripheral byte address (FIFO head).
- `io_WrData`, output, 32: peripheral write data (FIFO head).
- `io_Ack`, input, 1: peripheral accepts the head entry.

## Operation
- Region decode: `io_sel = me_ExtMemAddr[31]`.
- RAM region (`io_sel` = 0):
  - Index is `me_ExtMemAddr[DMEM_AW+1:2]`; bits above it alias; bits [1:0] are ignored.
  - Store writes the RAM at the clock edge.
  - Load returns `ram[index]` combinationally.
- I/O region stores: push {addr, data} into the FIFO if it is not full, or if a pop occurs in the same cycle. Otherwise the store is dropped and an overflow event fires.
- I/O region loads: return the status word:
  - bit0 = empty, bit1 = full, bit2 = overflow.
  - bits[11:8] = entry count.
  - All other bits 0.
- `me_ExtMemRdEn` = 0: `me_ExtMemRdData` = 0.
- `me_ExtMemWrEn` and `me_ExtMemRdEn` both high to the RAM region: the load returns pre-write data; the write completes at the edge.
- FIFO output:
  - `io_Req` = (count != 0), driven from registered state.
  - `io_Addr`/`io_WrData` = head entry.
  - Pop when `io_Req` && `io_Ack`.
  - `io_Ack` while `io_Req` = 0 is ignored.
- Head stability: head fields stay constant while `io_Req` = 1 until the pop.
- Ordering: entries drain in push order; no merging or reordering.
- Overflow bit:
  - Sticky; set on a dropped push.
  - Cleared at the edge following a status read.
  - A drop in the same cycle as a status read leaves it set (set wins).
- Pointers: read/write pointers are log2(WBUF_DEPTH) bits wide and wrap modulo depth. Count is tracked separately (0..WBUF_DEPTH).

## Timing
- RAM load latency: 0 cycles, combinational from address. A stored value is readable the cycle after the store.
- Posted store: `io_Req` rises the cycle after the push edge when the FIFO was empty.
- Throughput: with `io_Ack` held high, one entry pops per cycle. Push and pop together keep the count unchanged.
- Full + push + pop in the same cycle: the push is accepted, the count stays at WBUF_DEPTH, and no overflow is flagged.
- Reset (asserted at any time, including mid-handshake):
  - Pointers, count and overflow go to 0; `io_Req` = 0 immediately.
  - `io_Addr`/`io_WrData` = 0.
  - Pending FIFO entries are discarded.
  - RAM contents are not reset.

## Configuration
- `DMEM_IO_OVF_EN` defined: the sticky overflow bit is implemented as above.
- `DMEM_IO_OVF_EN` not defined: no overflow register. Status bit2 reads 0 and dropped stores are silently discarded. All other behaviour is identical.

## Test plan
- RAM store/load: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 → 0xDEADBEEF. Load 0x0000_1010 (alias, DMEM_AW=10) → 0xDEADBEEF.
- Posted write: store 0x55 to 0x8000_0004 with `io_Ack` = 0 for 3 cycles, then 1.
  - `io_Req` = 1 from the next cycle, with `io_Addr` = 0x8000_0004 and `io_WrData` = 0x55 held stable.
  - After the ack, `io_Req` = 0.
- Overflow: 5 I/O stores with `io_Ack` = 0.
  - First 4 queued, 5th dropped.
  - Status load → 0x0000_0406.
  - Next status load → 0x0000_0402.
  - Without `DMEM_IO_OVF_EN`, both loads return 0x0000_0402.
- Full push+pop: FIFO full, store with `io_Ack` = 1 → count stays 4, no overflow. Drained order matches push order.
- Reset mid-handshake: 2 entries queued, `io_Req` = 1, assert `reset` = 0 asynchronously.
  - `io_Req` = 0 immediately.
  - After release, status reads 0x0000_0001.
